start_screen_ctrl: RTL and testbench

- Title/game-flow controller that sits directly upstream of the start-screen text overlay.
- Drives the overlay's Start_Text enable, blinking the "PRESS ENTER TO START" prompt at a frame-locked rate.
- On the Enter key, runs a frame-counted countdown, then hands control to the game logic.
- Returns to the title screen after a game-over hold period.

---
 rtl/start_screen_ctrl_if.sv | 31 +++
 rtl/start_screen_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_start_screen_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/start_screen_ctrl_if.sv
// Bundle between the title/game-flow controller, the keyboard/game logic and the text overlay.
// master = controller side, slave = consumer side.
interface start_screen_ctrl_if;
    logic [7:0] keycode;
    logic       game_over;
    logic       Start_Text;
    logic       game_run;
    logic       game_reset;
    logic [1:0] countdown;
    logic [1:0] state_dbg;

    modport master (
        input  keycode,
        input  game_over,
        output Start_Text,
        output game_run,
        output game_reset,
        output countdown,
        output state_dbg
    );

    modport slave (
        output keycode,
        output game_over,
        input  Start_Text,
        input  game_run,
        input  game_reset,
        input  countdown,
        input  state_dbg
    );
endinterface

// File: rtl/start_screen_ctrl.sv
// Title-screen / countdown / play / game-over flow controller.
// Blinks the start prompt on frame ticks and hands off to game logic after a countdown.
module start_screen_ctrl #(
    parameter int unsigned BLINK_FRAMES     = 30,
    parameter logic [7:0]  START_KEY        = 8'h28,
    parameter int unsigned COUNT_STEPS      = 3,
    parameter int unsigned COUNT_FRAMES     = 60,
    parameter int unsigned OVER_HOLD_FRAMES = 120
) (
    input  logic CLK,
    input  logic RESET,
    input  logic frame_clk,
    start_screen_ctrl_if.master bus
);

    localparam int unsigned MAX_BC = (BLINK_FRAMES > COUNT_FRAMES) ? BLINK_FRAMES : COUNT_FRAMES;
    localparam int unsigned MAX_F  = (MAX_BC > OVER_HOLD_FRAMES) ? MAX_BC : OVER_HOLD_FRAMES;
    localparam int unsigned CNT_W  = (MAX_F > 1) ? $clog2(MAX_F) : 1;

    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(COUNT_FRAMES - 1);
    localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_TITLE = 2'd0,
        S_COUNT = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             blink_q, blink_n;
    logic [1:0]       countdown_q, countdown_n;
    logic             text_q, text_n;
    logic             run_q, run_n;
    logic             greset_q, greset_n;

    logic       frame_meta, frame_sync, frame_prev, frame_tick;
    logic [7:0] key_prev;
    logic       key_hit_c;

    // frame_clk crosses into CLK: 2-FF sync, edge detect, registered tick
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            frame_meta <= 1'b0;
            frame_sync <= 1'b0;
            frame_prev <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_meta <= frame_clk;
            frame_sync <= frame_meta;
            frame_prev <= frame_sync;
            frame_tick <= frame_sync & ~frame_prev;
        end
    end

    // Reset value START_KEY keeps a key held through reset from counting as a press
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) key_prev <= START_KEY;
        else        key_prev <= bus.keycode;
    end

    assign key_hit_c = (bus.keycode == START_KEY) && (key_prev != START_KEY);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_TITLE;
            cnt_q       <= '0;
            blink_q     <= 1'b1;
            countdown_q <= 2'd0;
            text_q      <= 1'b1;
            run_q       <= 1'b0;
            greset_q    <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            blink_q     <= blink_n;
            countdown_q <= countdown_n;
            text_q      <= text_n;
            run_q       <= run_n;
            greset_q    <= greset_n;
        end
    end

    // Next state and next registered outputs; the shared frame counter clears on every entry
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        blink_n     = blink_q;
        countdown_n = countdown_q;
        text_n      = text_q;
        run_n       = run_q;
        greset_n    = 1'b0;

        unique case (state_q)
            S_TITLE: begin
                text_n      = blink_q;
                run_n       = 1'b0;
                countdown_n = 2'd0;
                if (key_hit_c) begin
                    state_n     = S_COUNT;
                    cnt_n       = '0;
                    greset_n    = 1'b1;
                    countdown_n = 2'(COUNT_STEPS);
                    text_n      = 1'b0;
                end else if (frame_tick) begin
                    if (cnt_q == BLINK_LAST) begin
                        cnt_n   = '0;
                        blink_n = ~blink_q;
                        text_n  = ~blink_q;
                    end else begin
                        cnt_n = cnt_q + CNT_ONE;
                    end
                end
            end

            S_COUNT: begin
                text_n = 1'b0;
                run_n  = 1'b0;
                if (frame_tick) begin
                    if (cnt_q == COUNT_LAST) begin
                        cnt_n = '0;
                        // The step that would show 0 starts play instead
                        if (countdown_q <= 2'd1) begin
                            state_n     = S_PLAY;
                            countdown_n = 2'd0;
                            run_n       = 1'b1;
                        end else begin
                            countdown_n = countdown_q - 2'd1;
                        end
                    end else begin
                        cnt_n = cnt_q + CNT_ONE;
                    end
                end
            end

            S_PLAY: begin
                text_n      = 1'b0;
                run_n       = 1'b1;
                countdown_n = 2'd0;
                if (bus.game_over) begin
                    state_n = S_OVER;
                    cnt_n   = '0;
                    run_n   = 1'b0;
                    text_n  = 1'b1;
                end
            end

            S_OVER: begin
                text_n      = 1'b1;
                run_n       = 1'b0;
                countdown_n = 2'd0;
                if (frame_tick) begin
                    if (cnt_q == OVER_LAST) begin
                        state_n = S_TITLE;
                        cnt_n   = '0;
                        blink_n = 1'b1;
                    end else begin
                        cnt_n = cnt_q + CNT_ONE;
                    end
                end
            end

            default: begin
                state_n = S_TITLE;
                cnt_n   = '0;
                blink_n = 1'b1;
                text_n  = 1'b1;
                run_n   = 1'b0;
            end
        endcase
    end

    assign bus.Start_Text = text_q;
    assign bus.game_run   = run_q;
    assign bus.game_reset = greset_q;
    assign bus.countdown  = countdown_q;
    assign bus.state_dbg  = 2'(state_q);

endmodule

// File: tb/tb_start_screen_ctrl.sv
// Directed bench for start_screen_ctrl: blink, start, countdown, game-over hold, reset cases.
module tb_start_screen_ctrl;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic frame_clk = 1'b0;

    always #5 clk = ~clk;

    start_screen_ctrl_if ifc();

    start_screen_ctrl #(
        .BLINK_FRAMES     (2),
        .START_KEY        (8'h28),
        .COUNT_STEPS      (3),
        .COUNT_FRAMES     (2),
        .OVER_HOLD_FRAMES (4)
    ) dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .frame_clk (frame_clk),
        .bus       (ifc)
    );

    int n_checks     = 0;
    int n_pass       = 0;
    int reset_pulses = 0;
    int base;

    logic exp_text [0:6];
    logic [1:0] exp_cd [0:5];

    always @(negedge clk) if (ifc.game_reset === 1'b1) reset_pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One frame period of 100 CLK: rising edge, 50 CLK high, 50 CLK low
    task automatic frame();
        frame_clk = 1'b1;
        repeat (50) @(negedge clk);
        frame_clk = 1'b0;
        repeat (50) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_text"},   32'(ifc.Start_Text), 32'd1);
        check({tag, "_run"},    32'(ifc.game_run),   32'd0);
        check({tag, "_greset"}, 32'(ifc.game_reset), 32'd0);
        check({tag, "_cd"},     32'(ifc.countdown),  32'd0);
        check({tag, "_state"},  32'(ifc.state_dbg),  32'd0);
    endtask

    initial begin
        exp_text[0] = 1'b1; exp_text[1] = 1'b1; exp_text[2] = 1'b0; exp_text[3] = 1'b0;
        exp_text[4] = 1'b1; exp_text[5] = 1'b1; exp_text[6] = 1'b0;
        exp_cd[0] = 2'd3; exp_cd[1] = 2'd2; exp_cd[2] = 2'd2;
        exp_cd[3] = 2'd1; exp_cd[4] = 2'd1; exp_cd[5] = 2'd0;

        ifc.keycode   = 8'h00;
        ifc.game_over = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Title blink with no keys
        check("blink0", 32'(ifc.Start_Text), 32'(exp_text[0]));
        for (int i = 1; i <= 6; i++) begin
            frame();
            check($sformatf("blink%0d", i), 32'(ifc.Start_Text), 32'(exp_text[i]));
            check($sformatf("title_state%0d", i), 32'(ifc.state_dbg), 32'd0);
            check($sformatf("title_run%0d", i), 32'(ifc.game_run), 32'd0);
        end

        // Enter held 500 CLK gives one start
        base = reset_pulses;
        ifc.keycode = 8'h28;
        repeat (500) @(negedge clk);
        #1;
        check("start_pulses", 32'(reset_pulses - base), 32'd1);
        check("start_state", 32'(ifc.state_dbg), 32'd1);
        check("start_cd", 32'(ifc.countdown), 32'd3);
        check("start_text", 32'(ifc.Start_Text), 32'd0);
        check("start_run", 32'(ifc.game_run), 32'd0);
        ifc.keycode = 8'h00;
        @(negedge clk);

        // Countdown 3,2,1 at two frames each, then play
        for (int i = 0; i < 6; i++) begin
            frame();
            check($sformatf("cd%0d", i), 32'(ifc.countdown), 32'(exp_cd[i]));
        end
        check("play_run", 32'(ifc.game_run), 32'd1);
        check("play_state", 32'(ifc.state_dbg), 32'd2);
        check("play_text", 32'(ifc.Start_Text), 32'd0);

        // Game over, skip attempt, hold expiry
        ifc.game_over = 1'b1;
        @(posedge clk);
        #1;
        check("over_run", 32'(ifc.game_run), 32'd0);
        check("over_state", 32'(ifc.state_dbg), 32'd3);
        check("over_text", 32'(ifc.Start_Text), 32'd1);
        @(negedge clk);
        ifc.game_over = 1'b0;
        base = reset_pulses;
        ifc.keycode = 8'h28;
        repeat (20) @(negedge clk);
        ifc.keycode = 8'h00;
        repeat (5) @(negedge clk);
        #1;
        check("over_key_state", 32'(ifc.state_dbg), 32'd3);
        check("over_key_pulses", 32'(reset_pulses - base), 32'd0);
        repeat (3) frame();
        check("over_hold3_state", 32'(ifc.state_dbg), 32'd3);
        frame();
        check("over_done_state", 32'(ifc.state_dbg), 32'd0);
        check("over_done_text", 32'(ifc.Start_Text), 32'd1);
        check("over_done_run", 32'(ifc.game_run), 32'd0);

        // Enter held across reset release does not start
        ifc.keycode = 8'h28;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = reset_pulses;
        repeat (50) @(negedge clk);
        #1;
        check("held_state", 32'(ifc.state_dbg), 32'd0);
        check("held_pulses", 32'(reset_pulses - base), 32'd0);
        ifc.keycode = 8'h00;
        repeat (5) @(negedge clk);
        ifc.keycode = 8'h28;
        repeat (3) @(negedge clk);
        check("repress_state", 32'(ifc.state_dbg), 32'd1);
        check("repress_cd", 32'(ifc.countdown), 32'd3);
        ifc.keycode = 8'h00;

        // Async reset mid-COUNT
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_count");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Async reset mid-PLAY
        ifc.keycode = 8'h28;
        @(negedge clk);
        ifc.keycode = 8'h00;
        repeat (6) frame();
        check("pre_rst_play_state", 32'(ifc.state_dbg), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_play");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset cancels an in-flight game_reset pulse
        ifc.keycode = 8'h28;
        @(posedge clk);
        #1;
        check("inflight_greset", 32'(ifc.game_reset), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("cancel_greset", 32'(ifc.game_reset), 32'd0);
        check("cancel_state", 32'(ifc.state_dbg), 32'd0);
        ifc.keycode = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
